// File: rtl/conv2d_pkg.sv
// Shared types, default geometry and output-map size helpers for the stride-2 convolution path.
package conv2d_pkg;

    localparam int DEF_BIT_WIDTH    = 16;
    localparam int DEF_FILT_DIM     = 3;
    localparam int DEF_INPUT_WIDTH  = 9;
    localparam int DEF_INPUT_HEIGHT = 9;

    typedef logic signed [DEF_BIT_WIDTH-1:0] pixel_t;

    localparam int ROW_W = $clog2(DEF_INPUT_HEIGHT);
    localparam int COL_W = $clog2(DEF_INPUT_WIDTH);

    // Output windows along one image row for a stride-2 walk.
    function automatic int out_per_row(input int width, input int filt);
        return (width - filt) / 2 + 1;
    endfunction

    // Output windows along one image column for a stride-2 walk.
    function automatic int out_per_col(input int height, input int filt);
        return (height - filt) / 2 + 1;
    endfunction

endpackage

// File: rtl/conv2d_line_buffer.sv
// Enable-gated shift register that delays one image row (minus the window width) of pixels.
module conv2d_line_buffer
    import conv2d_pkg::*;
#(
    parameter int DEPTH = DEF_INPUT_WIDTH - DEF_FILT_DIM,
    parameter int WIDTH = DEF_BIT_WIDTH
) (
    input  logic             clock,
    input  logic             en_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] sr_q [DEPTH];

    // Shift storage; contents are don't-care until a full row has passed through.
    always_ff @(posedge clock) begin
        if (en_i) begin
            sr_q[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    assign data_o = sr_q[DEPTH-1];

endmodule

// File: rtl/conv2d_stride2_window.sv
// KxK window generator: line buffers plus window registers, emitting a window only at stride-2 positions.
module conv2d_stride2_window
    import conv2d_pkg::*;
#(
    parameter int FILT_DIM     = DEF_FILT_DIM,
    parameter int BIT_WIDTH    = DEF_BIT_WIDTH,
    parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
    parameter int INPUT_HEIGHT = DEF_INPUT_HEIGHT
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   in_valid,
    input  logic signed [BIT_WIDTH-1:0]            in_data,
    output logic                                   in_ready,
    input  logic                                   out_ready,
    output logic                                   out_valid,
    output logic [FILT_DIM*FILT_DIM*BIT_WIDTH-1:0] out_window,
    output logic [$clog2(INPUT_HEIGHT)-1:0]        out_row,
    output logic [$clog2(INPUT_WIDTH)-1:0]         out_col,
    output logic                                   frame_done
);

    localparam int ROW_BITS = $clog2(INPUT_HEIGHT);
    localparam int COL_BITS = $clog2(INPUT_WIDTH);
    localparam int WIN_BITS = FILT_DIM * FILT_DIM * BIT_WIDTH;
    localparam logic KM1_LSB = 1'((FILT_DIM - 1) % 2);

    logic                 in_ready_s;
    logic                 accept_s;
    logic [BIT_WIDTH-1:0] win_q [FILT_DIM][FILT_DIM];
    logic [BIT_WIDTH-1:0] win_d [FILT_DIM][FILT_DIM];
    logic [BIT_WIDTH-1:0] lb_out_s [FILT_DIM-1];
    logic [WIN_BITS-1:0]  win_flat_s;
    logic [ROW_BITS-1:0]  row_q, row_d, row_off_s;
    logic [COL_BITS-1:0]  col_q, col_d, col_off_s;
    logic                 last_row_s, last_col_s, win_done_s;
    logic                 out_valid_q, out_valid_d;
    logic [WIN_BITS-1:0]  out_window_q, out_window_d;
    logic [ROW_BITS-1:0]  out_row_q, out_row_d;
    logic [COL_BITS-1:0]  out_col_q, out_col_d;
    logic                 frame_done_q, frame_done_d;

    // A held, unconsumed window stalls the whole pipeline.
    assign in_ready_s = !out_valid_q || out_ready;
    assign accept_s   = in_valid && in_ready_s;

    // Line buffer r feeds window row r from the pixel leaving window row r+1.
    for (genvar r = 0; r < FILT_DIM - 1; r++) begin : g_lb
        conv2d_line_buffer #(
            .DEPTH (INPUT_WIDTH - FILT_DIM),
            .WIDTH (BIT_WIDTH)
        ) u_lb (
            .clock  (clock),
            .en_i   (accept_s),
            .data_i (win_q[r+1][0]),
            .data_o (lb_out_s[r])
        );
    end

    // Window next state: shift left, new column enters at the right.
    always_comb begin
        win_d = win_q;
        if (accept_s) begin
            for (int r = 0; r < FILT_DIM; r++) begin
                for (int c = 0; c < FILT_DIM - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
            end
            for (int r = 0; r < FILT_DIM - 1; r++) begin
                win_d[r][FILT_DIM-1] = lb_out_s[r];
            end
            win_d[FILT_DIM-1][FILT_DIM-1] = in_data;
        end else begin
            win_d = win_q;
        end
    end

    // Window data registers, intentionally not reset.
    always_ff @(posedge clock) begin
        win_q <= win_d;
    end

    // Flatten the next-state window so the emitted window includes the completing pixel.
    always_comb begin
        win_flat_s = '0;
        for (int r = 0; r < FILT_DIM; r++) begin
            for (int c = 0; c < FILT_DIM; c++) begin
                win_flat_s[(r*FILT_DIM+c)*BIT_WIDTH +: BIT_WIDTH] = win_d[r][c];
            end
        end
    end

    assign last_row_s = (row_q == ROW_BITS'(INPUT_HEIGHT - 1));
    assign last_col_s = (col_q == COL_BITS'(INPUT_WIDTH - 1));
    assign row_off_s  = row_q - ROW_BITS'(FILT_DIM - 1);
    assign col_off_s  = col_q - COL_BITS'(FILT_DIM - 1);

    // Raster position of the pixel being accepted.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (accept_s) begin
            if (last_col_s) begin
                col_d = '0;
                row_d = last_row_s ? '0 : row_q + ROW_BITS'(1);
            end else begin
                col_d = col_q + COL_BITS'(1);
            end
        end else begin
            row_d = row_q;
            col_d = col_q;
        end
    end

    // Even offset from the first full window <=> LSB matches that of K-1.
    assign win_done_s = accept_s
                     && (row_q >= ROW_BITS'(FILT_DIM - 1))
                     && (col_q >= COL_BITS'(FILT_DIM - 1))
                     && (row_q[0] == KM1_LSB)
                     && (col_q[0] == KM1_LSB);

    // Output holding register: load on completion, clear on a bare handshake.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_window_d = out_window_q;
        out_row_d    = out_row_q;
        out_col_d    = out_col_q;
        frame_done_d = accept_s && last_row_s && last_col_s;
        if (win_done_s) begin
            out_valid_d  = 1'b1;
            out_window_d = win_flat_s;
            out_row_d    = row_off_s >> 1;
            out_col_d    = col_off_s >> 1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Control and output state with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            row_q        <= '0;
            col_q        <= '0;
            out_valid_q  <= 1'b0;
            out_window_q <= '0;
            out_row_q    <= '0;
            out_col_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            row_q        <= row_d;
            col_q        <= col_d;
            out_valid_q  <= out_valid_d;
            out_window_q <= out_window_d;
            out_row_q    <= out_row_d;
            out_col_q    <= out_col_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_q;
    assign out_window = out_window_q;
    assign out_row    = out_row_q;
    assign out_col    = out_col_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv2d_stride2_window.sv
// Directed bench for conv2d_stride2_window with W=H=9, K=3; pixel value = base + row*16 + col.
module tb_conv2d_stride2_window;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [15:0]   in_data;
    logic          in_ready;
    logic          out_ready;
    logic          out_valid;
    logic [143:0]  out_window;
    logic [3:0]    out_row;
    logic [3:0]    out_col;
    logic          frame_done;

    int            total = 0;
    int            bad   = 0;
    int            exp_idx = 0;
    int            fd_cnt  = 0;
    int            base0 = 0;
    int            base1 = 0;
    logic          mon_en = 1'b0;
    logic          bubbles = 1'b0;
    logic          rnd_ready = 1'b0;
    logic [143:0]  saved_win;
    int            bp_guard;

    conv2d_stride2_window #(
        .FILT_DIM     (3),
        .BIT_WIDTH    (16),
        .INPUT_WIDTH  (9),
        .INPUT_HEIGHT (9)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_window (out_window),
        .out_row    (out_row),
        .out_col    (out_col),
        .frame_done (frame_done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Window for output (orow,ocol): element (r,c) = pixel (2*orow+r, 2*ocol+c).
    function automatic logic [143:0] exp_window(input int base, input int orow, input int ocol);
        logic [143:0] w;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                w[(r*3+c)*16 +: 16] = 16'(base + (2*orow + r)*16 + 2*ocol + c);
            end
        end
        return w;
    endfunction

    // Consumer side: every handshake must be the next window in raster order.
    always @(negedge clock) begin
        if (mon_en && out_valid && out_ready) begin : mon
            int k;
            int b;
            k = exp_idx % 16;
            b = (exp_idx < 16) ? base0 : base1;
            chk("window", 256'(out_window), 256'(exp_window(b, k/4, k%4)));
            chk("out_row", 256'(out_row), 256'(k/4));
            chk("out_col", 256'(out_col), 256'(k%4));
            exp_idx++;
        end
        if (mon_en && frame_done) begin
            fd_cnt++;
        end
    end

    task automatic send_pixel(input logic [15:0] v);
        logic acc;
        int   guard;
        if (bubbles && ($urandom_range(0, 9) < 3)) begin
            in_valid = 1'b0;
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clock); #1;
        end
        in_valid = 1'b1;
        in_data  = v;
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 1000) begin
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clock);
            acc = in_ready;
            @(posedge clock); #1;
            guard++;
        end
        if (!acc) chk("send_timeout", 256'(in_ready), 256'(1));
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int base, input int nrows, input logic b2b);
        for (int r = 0; r < nrows; r++) begin
            for (int c = 0; c < 9; c++) begin
                send_pixel(16'(base + r*16 + c));
                if (r == 2 && c == 2) chk("latency_valid", 256'(out_valid), 256'(1));
            end
        end
        if (nrows == 9) begin
            chk("frame_done_pulse", 256'(frame_done), 256'(1));
            if (!b2b) begin
                @(posedge clock); #1;
                chk("frame_done_clear", 256'(frame_done), 256'(0));
            end
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        repeat (4) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic check_idle();
        chk("idle_out_valid", 256'(out_valid), 256'(0));
        chk("idle_frame_done", 256'(frame_done), 256'(0));
        chk("idle_out_window", 256'(out_window), 256'(0));
        chk("idle_out_row", 256'(out_row), 256'(0));
        chk("idle_out_col", 256'(out_col), 256'(0));
        chk("idle_in_ready", 256'(in_ready), 256'(1));
    endtask

    task automatic new_scenario(input int b0, input int b1);
        exp_idx = 0;
        fd_cnt  = 0;
        base0   = b0;
        base1   = b1;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        check_idle();
        mon_en = 1'b1;

        // Full frame at full rate.
        new_scenario(0, 0);
        send_frame(0, 9, 1'b0);
        drain();
        chk("full_count", 256'(exp_idx), 256'(16));
        chk("full_fd_count", 256'(fd_cnt), 256'(1));

        // Backpressure on the first window.
        new_scenario(32'h100, 32'h100);
        out_ready = 1'b0;
        fork
            send_frame(32'h100, 9, 1'b0);
            begin
                bp_guard = 0;
                @(negedge clock);
                while (!out_valid && bp_guard < 300) begin
                    @(negedge clock);
                    bp_guard++;
                end
                chk("bp_wait_valid", 256'(out_valid), 256'(1));
                saved_win = out_window;
                chk("bp_first_window", 256'(saved_win), 256'(exp_window(32'h100, 0, 0)));
                repeat (5) begin
                    @(negedge clock);
                    chk("bp_in_ready", 256'(in_ready), 256'(0));
                    chk("bp_hold_valid", 256'(out_valid), 256'(1));
                    chk("bp_hold_window", 256'(out_window), 256'(saved_win));
                end
                @(posedge clock); #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_count", 256'(exp_idx), 256'(16));
        chk("bp_fd_count", 256'(fd_cnt), 256'(1));

        // Random input bubbles and consumer stalls.
        new_scenario(32'h500, 32'h500);
        bubbles   = 1'b1;
        rnd_ready = 1'b1;
        send_frame(32'h500, 9, 1'b0);
        bubbles   = 1'b0;
        rnd_ready = 1'b0;
        drain();
        chk("rnd_count", 256'(exp_idx), 256'(16));
        chk("rnd_fd_count", 256'(fd_cnt), 256'(1));

        // Reset after row 4, then a fresh frame with new values.
        new_scenario(32'h100, 32'h100);
        send_frame(32'h100, 5, 1'b0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check_idle();
        chk("partial_count", 256'(exp_idx), 256'(8));
        new_scenario(32'h200, 32'h200);
        send_frame(32'h200, 9, 1'b0);
        drain();
        chk("post_reset_count", 256'(exp_idx), 256'(16));

        // Two back-to-back frames.
        new_scenario(32'h300, 32'h400);
        send_frame(32'h300, 9, 1'b1);
        send_frame(32'h400, 9, 1'b0);
        drain();
        chk("b2b_count", 256'(exp_idx), 256'(32));
        chk("b2b_fd_count", 256'(fd_cnt), 256'(2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
